if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//   Instruction fetch queue between the PC register / instruction memory (F stage) and decode (D stage).
//   - Buffers up to DEPTH fetched {PC, instr} pairs so that a decode stall does not immediately stop fetch.
//   - Its in_ready output drives the PC register's En input.
//   - Its head entry is the D-stage instruction.
//   - On a branch/jump redirect it discards wrong-path entries, optionally keeping the delay slot.
// PARAMETERS
//   DEPTH     4            number of entries; power of two, >= 2
//   RESET_PC  32'h00003000 out_pc value whenever the queue is empty
// PORTS
//   clk        input   1      clock; all state updates on posedge
//   reset      input   1      asynchronous, active-high; clears all state immediately
//   in_valid   input   1      F stage presents a fetched instruction
//   in_pc      input   32     PC of the fetched instruction
//   in_instr   input   32     fetched instruction word
//   in_ready   output  1      queue can accept this cycle; drives PC En
//   out_valid  output  1      head entry is valid (D-stage instruction present)
//   out_pc     output  32     PC of the head entry
//   out_instr  output  32     instruction of the head entry
//   out_ready  input   1      D stage consumes the head this cycle (!stall)
//   flush      input   1      redirect: discard queued wrong-path entries
//   flush_keep input   1      with flush, retain the oldest surviving entry (delay slot)
//   count      output  clog2(DEPTH+1)  number of valid entries
// BEHAVIOUR
//   Storage and reset
//   - Circular buffer with rd_ptr and wr_ptr, each clog2(DEPTH) bits and wrapping modulo DEPTH.
//   - count register is held separately.
//   - While reset is high: rd_ptr=0, wr_ptr=0, count=0, so in_ready=1, out_valid=0, out_pc=RESET_PC, out_instr=0.
//   - Entry storage is not reset.
//   Outputs
//   - All outputs are combinational from registered state only; no combinational in->out path.
//   - in_ready  = (count != DEPTH). It does not depend on out_ready, so a full queue refuses a push even when a pop occurs.
//   - out_valid = (count != 0).
//   - out_pc / out_instr: head entry when out_valid; otherwise RESET_PC / 32'h0 (nop).
//   Handshake, per cycle
//   - push = in_valid & in_ready.
//   - pop  = out_valid & out_ready.
//   - Push writes the entry at wr_ptr and increments wr_ptr. Pop increments rd_ptr.
//   - count' = count + push - pop.
//   - Push and pop in the same cycle leave count unchanged.
//   - Latency: an entry pushed in cycle N is visible at out_* in cycle N+1 if the queue was empty. There is no bypass.
//   Flush (synchronous; overrides push)
//   - Any push in a flush cycle is discarded.
//   - The pop still takes effect: the branch leaves for E in the same cycle.
//   - Let S = count - pop, the number of surviving entries.
//   - flush=1, flush_keep=0: count'=0, rd_ptr'=wr_ptr.
//   - flush=1, flush_keep=1, S>=1: keep only the entry at rd_ptr+pop; count'=1, wr_ptr'=rd_ptr+pop+1 (mod DEPTH).
//   - flush=1, flush_keep=1, S=0: count'=0, as for flush_keep=0.
//   - flush_keep is ignored when flush=0.
//   Boundaries
//   - Full queue: in_ready=0 and PC holds. Full with out_ready=1: one pop, count=DEPTH-1 next cycle.
//   - Empty queue: a pop cannot occur; out_ready is ignored.
//   - Pointer wrap: DEPTH-1 -> 0 with no loss of ordering.
//   - Reset asserted mid-operation: all entries are discarded asynchronously. Outputs take their reset values within the same cycle.
//   - count never exceeds DEPTH and never underflows. Add a simulation-only assertion for both.
// TESTING
//   1 Reset -> in_ready=1, out_valid=0, out_pc=0x3000, out_instr=0, count=0.
//   2 Fill: push 0x3000..0x300C with out_ready=0
//     -> count=4 and in_ready=0 after the 4th push.
//     -> 5th in_valid (0x3010) not accepted; head stays 0x3000.
//   3 Full, push+pop: queue full, out_ready=1, in_valid=1
//     -> 0x3000 popped, push refused, count=3.
//     -> next cycle push accepted, count=4.
//   4 Streaming: continuous in_valid with out_ready=1 over 10 instructions
//     -> out_pc = 0x3000, 0x3004, ... in order, one per cycle after 1-cycle latency.
//     -> count stays 1 and pointers wrap correctly.
//   5 Flush with keep: queue holds 0x3000 (beq), 0x3004, 0x3008; flush=1, flush_keep=1, out_ready=1, in_valid=1 (0x300C)
//     -> next cycle count=1, out_pc=0x3004, 0x300C dropped.
//   6 Flush without keep / reset mid-operation
//     -> flush_keep=0 with 3 entries: count=0 next cycle.
//     -> reset asserted between edges with 2 entries: out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: circular instruction fetch queue between the F and D stages.
// Holds {PC, instr} pairs; supports redirect flush, optionally keeping the delay slot.
`default_nettype none

module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [31:0]                  in_pc,
  input  logic [31:0]                  in_instr,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_instr,
  input  logic                         out_ready,
  input  logic                         flush,
  input  logic                         flush_keep,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_r;

  logic          push;
  logic          pop;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] survivors;

  assign in_ready  = (count_r != CW'(DEPTH));
  assign out_valid = (count_r != '0);
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : RESET_PC;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'h0;
  assign count     = count_r;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign rd_next   = rd_ptr + AW'(pop);
  assign survivors = count_r - CW'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_r <= '0;
    end else if (flush) begin
      // The popped branch still leaves; only its successor may survive as delay slot.
      if (flush_keep && (survivors != '0)) begin
        rd_ptr  <= rd_next;
        wr_ptr  <= rd_next + AW'(1);
        count_r <= CW'(1);
      end else begin
        rd_ptr  <= wr_ptr;
        count_r <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_next;
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_r <= CW'(DEPTH)) else $error("fetch queue count overflow: %0d", count_r);
      assert (!(pop && count_r == '0)) else $error("fetch queue count underflow");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: driver updates a queue-based model, monitor compares.
`default_nettype none

module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    int          cnt;
    logic        ir;
    logic        ov;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [31:0]   in_pc = '0;
  logic [31:0]   in_instr = '0;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          flush_keep = 1'b0;
  logic [CW-1:0] count;

  int vectors = 0;
  int miscompares = 0;

  entry_t mq[$];
  exp_t   exp_q[$];

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .flush(flush), .flush_keep(flush_keep), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; the model advances by the queue's architectural rules.
  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl, input logic kp);
    int   n;
    logic psh, pp;
    exp_t e;
    entry_t k;
    @(negedge clk);
    in_valid = iv; in_pc = pc; in_instr = ins;
    out_ready = ordy; flush = fl; flush_keep = kp;
    n   = mq.size();
    psh = iv && (n < DEPTH);
    pp  = ordy && (n > 0);
    if (pp) void'(mq.pop_front());
    if (fl) begin
      if (kp && mq.size() > 0) begin
        k = mq[0];
        mq.delete();
        mq.push_back(k);
      end else begin
        mq.delete();
      end
    end else if (psh) begin
      k.pc = pc; k.instr = ins;
      mq.push_back(k);
    end
    e.cnt   = mq.size();
    e.ir    = (mq.size() < DEPTH);
    e.ov    = (mq.size() > 0);
    e.pc    = e.ov ? mq[0].pc    : RESET_PC;
    e.instr = e.ov ? mq[0].instr : 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; flush_keep = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",     32'(count),     32'(e.cnt));
        chk("in_ready",  32'(in_ready),  32'(e.ir));
        chk("out_valid", 32'(out_valid), 32'(e.ov));
        chk("out_pc",    out_pc,         e.pc);
        chk("out_instr", out_instr,      e.instr);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : driver
    #2;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc",    out_pc,         RESET_PC);
    chk("rst_out_instr", out_instr,      32'h0);
    chk("rst_count",     32'(count),     32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fill to full, then a refused fifth push.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h3000 + 32'(4*i), 32'hA000 + 32'(i), 1'b0, 1'b0, 1'b0);
    // Full: pop with push refused, then push accepted.
    step(1'b1, 32'h3010, 32'hA004, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h3010, 32'hA004, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Streaming ten instructions through with pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h3000 + 32'(4*i), 32'hB000 + 32'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush keeping the delay slot while the branch pops and a push is dropped.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3000 + 32'(4*i), 32'hC000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h300C, 32'hC003, 1'b1, 1'b1, 1'b1);

    // Flush without keep with three entries.
    step(1'b1, 32'h3008, 32'hC002, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h300C, 32'hC003, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Reset asserted between edges with two entries queued.
    step(1'b1, 32'h4000, 32'hD000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h4004, 32'hD001, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    idle();
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count",     32'(count),     32'd0);
    chk("mid_rst_out_pc",    out_pc,         RESET_PC);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic fl;
      fl = ($urandom_range(0, 7) == 0);
      step(1'($urandom), 32'h5000 + 32'(4*i), $urandom, 1'($urandom_range(0, 2) != 0),
           fl, 1'($urandom));
    end

    @(negedge clk);
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
